// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Decode inputs and per-stage control outputs of the MIPS
//            pipeline control unit, bundled for the control block and its
//            datapath-side driver.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4
);
  // ID-stage instruction fields and EX-stage ALU flag
  logic [5:0]           Opcode;
  logic [5:0]           Func;
  logic [REG_AW-1:0]    RsD;
  logic [REG_AW-1:0]    RtD;
  logic [REG_AW-1:0]    RdD;
  logic                 ZeroE;

  // ID-stage combinational controls
  logic                 ZeroExtD;
  logic                 JumpD;
  logic                 IllegalD;

  // EX-stage controls
  logic [ALUCTRL_W-1:0] ALUctrlE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic                 PCSrcE;
  logic [REG_AW-1:0]    WriteRegE;

  // MEM-stage controls
  logic [REG_AW-1:0]    WriteRegM;
  logic                 MemWriteM;
  logic                 RegWriteM;
  logic                 MemtoRegM;

  // WB-stage controls
  logic [REG_AW-1:0]    WriteRegW;
  logic                 RegWriteW;
  logic                 MemtoRegW;

  // Hazard handling
  logic                 StallF;
  logic                 StallD;
  logic                 FlushD;
  logic                 FlushE;

  // Datapath side: supplies the instruction, consumes the controls
  modport master (
    output Opcode, Func, RsD, RtD, RdD, ZeroE,
    input  ZeroExtD, JumpD, IllegalD,
    input  ALUctrlE, ALUSrcE, RegDstE, PCSrcE, WriteRegE,
    input  WriteRegM, MemWriteM, RegWriteM, MemtoRegM,
    input  WriteRegW, RegWriteW, MemtoRegW,
    input  StallF, StallD, FlushD, FlushE
  );

  // Control-unit side
  modport slave (
    input  Opcode, Func, RsD, RtD, RdD, ZeroE,
    output ZeroExtD, JumpD, IllegalD,
    output ALUctrlE, ALUSrcE, RegDstE, PCSrcE, WriteRegE,
    output WriteRegM, MemWriteM, RegWriteM, MemtoRegM,
    output WriteRegW, RegWriteW, MemtoRegW,
    output StallF, StallD, FlushD, FlushE
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipelined main/ALU control for a five-stage MIPS datapath.
//            Decodes in ID, carries the control word through ID/EX, EX/MEM
//            and MEM/WB, detects load-use hazards and resolves branches in
//            EX and jumps in ID.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(7);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  // ID-stage decoded controls
  logic                 reg_write_d, reg_dst_d, alu_src_d, branch_d, bne_d;
  logic                 mem_write_d, mem_to_reg_d, jump_d, zero_ext_d, illegal_d;
  logic                 uses_rs_d, uses_rt_d;
  logic [ALUCTRL_W-1:0] alu_ctrl_d;

  // ID/EX register
  logic                 reg_write_e, reg_dst_e, alu_src_e, branch_e, bne_e;
  logic                 mem_write_e, mem_to_reg_e;
  logic [ALUCTRL_W-1:0] alu_ctrl_e;
  logic [REG_AW-1:0]    rt_e, rd_e;

  // EX/MEM register
  logic                 reg_write_m, mem_write_m, mem_to_reg_m;
  logic [REG_AW-1:0]    write_reg_m;

  // MEM/WB register
  logic                 reg_write_w, mem_to_reg_w;
  logic [REG_AW-1:0]    write_reg_w;

  // Hazard / redirect terms
  logic                 lw_stall, pc_src_e, flush_e, jump_taken;
  logic [REG_AW-1:0]    write_reg_e;

  // Main and ALU decode; unsupported encodings yield all-zero controls
  always_comb begin
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    bne_d        = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    jump_d       = 1'b0;
    zero_ext_d   = 1'b0;
    illegal_d    = 1'b0;
    uses_rs_d    = 1'b0;
    uses_rt_d    = 1'b0;
    alu_ctrl_d   = ALU_AND;
    case (bus.Opcode)
      OP_RTYPE: begin
        uses_rs_d = 1'b1;
        uses_rt_d = 1'b1;
        case (bus.Func)
          FN_ADD:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_ADD; end
          FN_SUB:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_SUB; end
          FN_AND:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_AND; end
          FN_OR:   begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_OR;  end
          FN_SLT:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_SLT; end
          default: illegal_d = 1'b1;
        endcase
      end
      OP_LW: begin
        uses_rs_d    = 1'b1;
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_ctrl_d   = ALU_ADD;
      end
      OP_SW: begin
        uses_rs_d   = 1'b1;
        uses_rt_d   = 1'b1;
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        alu_ctrl_d  = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        uses_rs_d  = 1'b1;
        uses_rt_d  = 1'b1;
        branch_d   = 1'b1;
        bne_d      = (bus.Opcode == OP_BNE);
        alu_ctrl_d = ALU_SUB;
      end
      OP_ADDI, OP_SLTI: begin
        uses_rs_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = (bus.Opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_ANDI, OP_ORI: begin
        uses_rs_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        zero_ext_d  = 1'b1;
        alu_ctrl_d  = (bus.Opcode == OP_ORI) ? ALU_OR : ALU_AND;
      end
      OP_J:    jump_d    = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  assign write_reg_e = reg_dst_e ? rd_e : rt_e;

  // Load-use detection against the instruction currently in EX
  generate
    if (HAZARD_EN) begin : g_hazard
      assign lw_stall = mem_to_reg_e && reg_write_e && (write_reg_e != '0) &&
                        ((uses_rs_d && (bus.RsD == write_reg_e)) ||
                         (uses_rt_d && (bus.RtD == write_reg_e)));
    end else begin : g_no_hazard
      assign lw_stall = 1'b0;
    end
  endgenerate

  // A taken branch outranks both the stall and a jump in ID
  assign pc_src_e   = branch_e & (bus.ZeroE ^ bne_e);
  assign jump_taken = jump_d & ~pc_src_e & ~lw_stall;
  assign flush_e    = pc_src_e | lw_stall;

  // ID/EX register; a flush inserts a bubble with all-zero controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush_e) begin
      reg_write_e  <= 1'b0;
      reg_dst_e    <= 1'b0;
      alu_src_e    <= 1'b0;
      branch_e     <= 1'b0;
      bne_e        <= 1'b0;
      mem_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      alu_ctrl_e   <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
    end else begin
      reg_write_e  <= reg_write_d;
      reg_dst_e    <= reg_dst_d;
      alu_src_e    <= alu_src_d;
      branch_e     <= branch_d;
      bne_e        <= bne_d;
      mem_write_e  <= mem_write_d;
      mem_to_reg_e <= mem_to_reg_d;
      alu_ctrl_e   <= alu_ctrl_d;
      rt_e         <= bus.RtD;
      rd_e         <= bus.RdD;
    end
  end

  // EX/MEM and MEM/WB always advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      write_reg_m  <= '0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      write_reg_w  <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      mem_to_reg_m <= mem_to_reg_e;
      write_reg_m  <= write_reg_e;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      write_reg_w  <= write_reg_m;
    end
  end

  assign bus.ZeroExtD  = zero_ext_d;
  assign bus.JumpD     = jump_taken;
  assign bus.IllegalD  = illegal_d;
  assign bus.ALUctrlE  = alu_ctrl_e;
  assign bus.ALUSrcE   = alu_src_e;
  assign bus.RegDstE   = reg_dst_e;
  assign bus.PCSrcE    = pc_src_e;
  assign bus.WriteRegE = write_reg_e;
  assign bus.WriteRegM = write_reg_m;
  assign bus.MemWriteM = mem_write_m;
  assign bus.RegWriteM = reg_write_m;
  assign bus.MemtoRegM = mem_to_reg_m;
  assign bus.WriteRegW = write_reg_w;
  assign bus.RegWriteW = reg_write_w;
  assign bus.MemtoRegW = mem_to_reg_w;
  assign bus.StallF    = lw_stall & ~pc_src_e;
  assign bus.StallD    = lw_stall & ~pc_src_e;
  assign bus.FlushD    = pc_src_e | jump_taken;
  assign bus.FlushE    = flush_e;

endmodule
`default_nettype wire
